// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access sizes and FSM states.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: request/grant/rvalid, one access in flight.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: byte enables, store replication, load extraction, misalignment.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  input  logic        unsigned_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  logic [31:0] w_shifted;

  assign w_shifted = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = wdata_i;
    rdata_o      = w_shifted;
    misaligned_o = 1'b0;
    case (size_i)
      LSU_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{w_shifted[7] & ~unsigned_i}}, w_shifted[7:0]};
      end
      LSU_HALF: begin
        be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = {2{wdata_i[15:0]}};
        rdata_o      = {{16{w_shifted[15] & ~unsigned_i}}, w_shifted[15:0]};
        misaligned_o = addr_lo_i[0];
      end
      LSU_WORD: begin
        be_o         = 4'b1111;
        misaligned_o = |addr_lo_i;
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: issues one data-memory access at a time and returns aligned load data
// or store completion, flagging misalignment, bus errors and timeouts.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_i,
  load_store_unit_if.master mem,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic [4:0]  rsp_rd_o,
  output logic        rsp_misaligned_o,
  output logic        rsp_fault_o
);

  localparam int CNT_W = (BUS_TIMEOUT == 0) ? 1 : $clog2(BUS_TIMEOUT + 1);

  lsu_state_e       r_state;
  logic             r_req_ready;
  logic             r_mem_req;
  logic             r_we;
  logic [1:0]       r_size;
  logic             r_unsigned;
  logic [1:0]       r_addr_lo;
  logic [4:0]       r_rd;
  logic [31:0]      r_mem_addr;
  logic [3:0]       r_mem_be;
  logic [31:0]      r_mem_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_rdata;
  logic [4:0]       r_rsp_rd;
  logic             r_rsp_misaligned;
  logic             r_rsp_fault;

  logic             w_idle;
  logic             w_accept;
  logic [1:0]       w_size;
  logic [1:0]       w_addr_lo;
  logic             w_unsigned;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata_rep;
  logic [31:0]      w_rdata_ext;
  logic             w_misaligned;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_timeout;

  // One aligner serves both directions: live request fields while idle, captured ones afterwards.
  assign w_idle     = (r_state == IDLE);
  assign w_accept   = req_valid_i & r_req_ready;
  assign w_size     = w_idle ? req_size_i     : r_size;
  assign w_addr_lo  = w_idle ? addr_i[1:0]    : r_addr_lo;
  assign w_unsigned = w_idle ? req_unsigned_i : r_unsigned;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_timeout  = (BUS_TIMEOUT != 0) && (w_cnt_inc == CNT_W'(BUS_TIMEOUT));

  lsu_align u_align (
    .size_i       (w_size),
    .addr_lo_i    (w_addr_lo),
    .wdata_i      (wdata_i),
    .rdata_i      (mem.mem_rdata),
    .unsigned_i   (w_unsigned),
    .be_o         (w_be),
    .wdata_o      (w_wdata_rep),
    .rdata_o      (w_rdata_ext),
    .misaligned_o (w_misaligned)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state          <= IDLE;
      r_req_ready      <= 1'b1;
      r_mem_req        <= 1'b0;
      r_we             <= 1'b0;
      r_size           <= 2'b00;
      r_unsigned       <= 1'b0;
      r_addr_lo        <= 2'b00;
      r_rd             <= 5'd0;
      r_mem_addr       <= 32'd0;
      r_mem_be         <= 4'd0;
      r_mem_wdata      <= 32'd0;
      r_cnt            <= '0;
      r_rsp_valid      <= 1'b0;
      r_rsp_rdata      <= 32'd0;
      r_rsp_rd         <= 5'd0;
      r_rsp_misaligned <= 1'b0;
      r_rsp_fault      <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_we        <= req_we_i;
            r_size      <= req_size_i;
            r_unsigned  <= req_unsigned_i;
            r_addr_lo   <= addr_i[1:0];
            r_rd        <= rd_i;
            r_mem_addr  <= {addr_i[31:2], 2'b00};
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata_rep;
            r_cnt       <= '0;
            if (w_misaligned) begin
              r_state          <= RESP;
              r_rsp_valid      <= 1'b1;
              r_rsp_rdata      <= 32'd0;
              r_rsp_rd         <= rd_i;
              r_rsp_misaligned <= 1'b1;
              r_rsp_fault      <= 1'b0;
            end else begin
              r_state   <= REQ;
              r_mem_req <= 1'b1;
            end
          end
        end
        REQ: begin
          r_cnt <= w_cnt_inc;
          if (w_timeout) begin
            r_state          <= RESP;
            r_mem_req        <= 1'b0;
            r_rsp_valid      <= 1'b1;
            r_rsp_rdata      <= 32'd0;
            r_rsp_rd         <= r_rd;
            r_rsp_misaligned <= 1'b0;
            r_rsp_fault      <= 1'b1;
          end else if (mem.mem_gnt) begin
            r_state   <= WAIT;
            r_mem_req <= 1'b0;
          end
        end
        WAIT: begin
          r_cnt <= w_cnt_inc;
          if (w_timeout) begin
            r_state          <= RESP;
            r_rsp_valid      <= 1'b1;
            r_rsp_rdata      <= 32'd0;
            r_rsp_rd         <= r_rd;
            r_rsp_misaligned <= 1'b0;
            r_rsp_fault      <= 1'b1;
          end else if (mem.mem_rvalid) begin
            r_state          <= RESP;
            r_rsp_valid      <= 1'b1;
            r_rsp_rdata      <= (mem.mem_err | r_we) ? 32'd0 : w_rdata_ext;
            r_rsp_rd         <= r_rd;
            r_rsp_misaligned <= 1'b0;
            r_rsp_fault      <= mem.mem_err;
          end
        end
        RESP: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_mem_req   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o      = r_req_ready;
  assign mem.mem_req      = r_mem_req;
  assign mem.mem_addr     = r_mem_addr;
  assign mem.mem_we       = r_we;
  assign mem.mem_be       = r_mem_be;
  assign mem.mem_wdata    = r_mem_wdata;
  assign rsp_valid_o      = r_rsp_valid;
  assign rsp_rdata_o      = r_rsp_rdata;
  assign rsp_rd_o         = r_rsp_rd;
  assign rsp_misaligned_o = r_rsp_misaligned;
  assign rsp_fault_o      = r_rsp_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: bus responder tasks plus a response scoreboard.
module tb_load_store_unit;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        mis;
    logic        fault;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic [4:0]  rsp_rd_o;
  logic        rsp_misaligned_o;
  logic        rsp_fault_o;

  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];

  load_store_unit_if bus();

  load_store_unit #(.BUS_TIMEOUT(8)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_we_i         (req_we_i),
    .req_size_i       (req_size_i),
    .req_unsigned_i   (req_unsigned_i),
    .addr_i           (addr_i),
    .wdata_i          (wdata_i),
    .rd_i             (rd_i),
    .mem              (bus),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_rdata_o      (rsp_rdata_o),
    .rsp_rd_o         (rsp_rd_o),
    .rsp_misaligned_o (rsp_misaligned_o),
    .rsp_fault_o      (rsp_fault_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && rsp_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("spurious_rsp", 32'(rsp_valid_o), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("rsp_rdata", rsp_rdata_o, e.rdata);
        check_val("rsp_rd", 32'(rsp_rd_o), 32'(e.rd));
        check_val("rsp_mis", 32'(rsp_misaligned_o), 32'(e.mis));
        check_val("rsp_fault", 32'(rsp_fault_o), 32'(e.fault));
        $display("rsp rd=%0d rdata=%08h mis=%0b fault=%0b", rsp_rd_o, rsp_rdata_o,
                 rsp_misaligned_o, rsp_fault_o);
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of the cycle after accept.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                       input logic push, input logic [31:0] e_rdata, input logic e_mis,
                       input logic e_fault);
    exp_t e;
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    addr_i         = addr;
    wdata_i        = wd;
    rd_i           = rd;
    e.rdata = e_rdata;
    e.rd    = rd;
    e.mis   = e_mis;
    e.fault = e_fault;
    if (push) sb.push_back(e);
    @(negedge clk_i);
    check_val("req_ready", 32'(req_ready_o), 1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  // Grant after gnt_delay cycles, rvalid on the following cycle, then expect the response.
  task automatic serve(input int gnt_delay, input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic e_we, input logic [31:0] e_wdata,
                       input logic [31:0] rdata, input logic err);
    for (int i = 0; i <= gnt_delay; i++) begin
      if (i == gnt_delay) bus.mem_gnt = 1'b1;
      @(negedge clk_i);
      check_val("mem_req", 32'(bus.mem_req), 1);
      check_val("mem_addr", bus.mem_addr, e_addr);
      check_val("mem_be", 32'(bus.mem_be), 32'(e_be));
      check_val("mem_we", 32'(bus.mem_we), 32'(e_we));
      check_val("mem_wdata", bus.mem_wdata, e_wdata);
      @(posedge clk_i); #1;
      bus.mem_gnt = 1'b0;
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    bus.mem_err    = err;
    @(negedge clk_i);
    check_val("wait_req_low", 32'(bus.mem_req), 0);
    check_val("wait_no_rsp", 32'(rsp_valid_o), 0);
    @(posedge clk_i); #1;
    bus.mem_rvalid = 1'b0;
    bus.mem_err    = 1'b0;
    @(negedge clk_i);
    check_val("rsp_latency", 32'(rsp_valid_o), 1);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni         = 1'b0;
    req_valid_i    = 1'b0;
    req_we_i       = 1'b0;
    req_size_i     = 2'b00;
    req_unsigned_i = 1'b0;
    addr_i         = 32'd0;
    wdata_i        = 32'd0;
    rd_i           = 5'd0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;
    bus.mem_err    = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_val("rst_ready", 32'(req_ready_o), 1);
    check_val("rst_mem_req", 32'(bus.mem_req), 0);
    check_val("rst_rsp_valid", 32'(rsp_valid_o), 0);
    check_val("rst_rsp_rdata", rsp_rdata_o, 0);
    check_val("rst_mem_be", 32'(bus.mem_be), 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // LW 0x1000
    issue(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 5'd1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    serve(0, 32'h0000_1000, 4'hF, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    // LB / LBU 0x1003
    issue(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 5'd2, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0);
    serve(0, 32'h0000_1000, 4'b1000, 1'b0, 32'h0, 32'h80FF_0000, 1'b0);
    issue(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 5'd3, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
    serve(0, 32'h0000_1000, 4'b1000, 1'b0, 32'h0, 32'h80FF_0000, 1'b0);
    // SH 0x2002
    issue(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 5'd4, 1'b1, 32'h0, 1'b0, 1'b0);
    serve(0, 32'h0000_2000, 4'b1100, 1'b1, 32'hABCD_ABCD, 32'h5555_5555, 1'b0);
    // LH / LHU / SB lane variants
    issue(1'b0, 2'b01, 1'b0, 32'h0000_4002, 32'h0, 5'd5, 1'b1, 32'hFFFF_8001, 1'b0, 1'b0);
    serve(0, 32'h0000_4000, 4'b1100, 1'b0, 32'h0, 32'h8001_7777, 1'b0);
    issue(1'b0, 2'b01, 1'b1, 32'h0000_4000, 32'h0, 5'd6, 1'b1, 32'h0000_F00F, 1'b0, 1'b0);
    serve(0, 32'h0000_4000, 4'b0011, 1'b0, 32'h0, 32'h1234_F00F, 1'b0);
    issue(1'b1, 2'b00, 1'b0, 32'h0000_5001, 32'h0000_00A5, 5'd7, 1'b1, 32'h0, 1'b0, 1'b0);
    serve(0, 32'h0000_5000, 4'b0010, 1'b1, 32'hA5A5_A5A5, 32'h0, 1'b0);
    // SW with grant withheld 5 cycles
    issue(1'b1, 2'b10, 1'b0, 32'h0000_3004, 32'hCAFE_F00D, 5'd8, 1'b1, 32'h0, 1'b0, 1'b0);
    serve(5, 32'h0000_3004, 4'hF, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b0);
    // bus error on a load
    issue(1'b0, 2'b01, 1'b0, 32'h0000_4002, 32'h0, 5'd10, 1'b1, 32'h0, 1'b0, 1'b1);
    serve(0, 32'h0000_4000, 4'b1100, 1'b0, 32'h0, 32'h1234_5678, 1'b1);

    // Misaligned: LW 0x1001, LH 0x1003, reserved size
    for (int k = 0; k < 3; k++) begin
      logic [1:0]  sz;
      logic [31:0] ad;
      sz = (k == 0) ? 2'b10 : (k == 1) ? 2'b01 : 2'b11;
      ad = (k == 0) ? 32'h0000_1001 : (k == 1) ? 32'h0000_1003 : 32'h0000_1000;
      issue(1'b0, sz, 1'b0, ad, 32'h0, 5'(11 + k), 1'b1, 32'h0, 1'b1, 1'b0);
      @(negedge clk_i);
      check_val("mis_no_req", 32'(bus.mem_req), 0);
      check_val("mis_latency", 32'(rsp_valid_o), 1);
      @(posedge clk_i); #1;
    end

    // Timeout: no grant ever, fault after 8 cycles in REQ
    issue(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0, 5'd20, 1'b1, 32'h0, 1'b0, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_i);
      check_val("to_req_held", 32'(bus.mem_req), 1);
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    check_val("to_req_drop", 32'(bus.mem_req), 0);
    check_val("to_rsp", 32'(rsp_valid_o), 1);
    @(posedge clk_i); #1;
    // Stray rvalid while idle
    bus.mem_rvalid = 1'b1;
    @(posedge clk_i); #1;
    bus.mem_rvalid = 1'b0;
    @(negedge clk_i);
    check_val("stray_rvalid", 32'(rsp_valid_o), 0);
    @(posedge clk_i); #1;

    // Reset during WAIT, then a late rvalid
    issue(1'b0, 2'b10, 1'b0, 32'h0000_7000, 32'h0, 5'd21, 1'b0, 32'h0, 1'b0, 1'b0);
    bus.mem_gnt = 1'b1;
    @(posedge clk_i); #1;
    bus.mem_gnt = 1'b0;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_2222;
    @(negedge clk_i);
    check_val("rstw_ready", 32'(req_ready_o), 1);
    check_val("rstw_mem_req", 32'(bus.mem_req), 0);
    check_val("rstw_rsp", 32'(rsp_valid_o), 0);
    @(posedge clk_i); #1;
    bus.mem_rvalid = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      check_val("late_rvalid", 32'(rsp_valid_o), 0);
      @(posedge clk_i); #1;
    end

    check_val("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
